gate_identifier: RTL
====================

Name: gate_identifier

Overview:
- Sequential truth-table sweeper for any 2-input combinational gate.
- Drives the four input vectors onto an external gate, samples its output, assembles a 4-bit truth table and classifies it.
- Reports the gate type (AND/OR/NAND/NOR/XOR/XNOR/NOT/constant) and whether it is a universal gate.
- Counterpart to the universal-gate builders: those synthesise functions from NOR; this block recovers the function from observed behaviour. Used in self-test benches and FPGA demo boards.

Parameters:
SETTLE_CYCLES, 2, extra cycles each vector is held before sampling; legal range 0..15.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a sweep; sampled only in IDLE
gate_y  input  1  output of the gate under identification
gate_a  output  1  drive to gate input A
gate_b  output  1  drive to gate input B
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse when results become valid
truth_tbl  output  4  bit i = gate_y observed with {gate_a,gate_b}=i (a is MSB)
gate_id  output  4  classification code, see Behaviour
is_universal  output  1  gate_id is NAND or NOR
stable  output  1  repeat sweep matched the first sweep (see Optional Feature)

Behaviour:
- Clock and reset: one clock `clk`. `rst` is asynchronous and active-high.
- Reset values: all outputs are 0, state is IDLE, the vector index is 0 and the settle counter is 0.
- Reset mid-sweep: abort immediately. Return to IDLE with all outputs cleared; there is no partial result.
- FSM states:
  - IDLE: busy=0. A rising edge with start=1 goes to RUN with idx=0, cnt=0, busy=1, truth_tbl cleared.
  - RUN: {gate_a,gate_b}=idx, registered, so they are valid from the cycle after the start edge.
    - cnt increments every cycle.
    - When cnt==SETTLE_CYCLES, the edge writes truth_tbl[idx]<=gate_y, sets cnt<=0 and idx<=idx+1.
    - When idx==3 is sampled, go to DONE.
  - DONE: a single cycle. done=1, busy=0, gate_id/is_universal/stable updated, gate_a=gate_b=0. Next state is IDLE.
- Latency: done is high in cycle 4*(SETTLE_CYCLES+1)+1 counted from the start edge. With the default that is cycle 13.
- start while busy is ignored. start held high continuously re-launches a sweep on the IDLE cycle after each DONE.
- gate_y must be stable within SETTLE_CYCLES+1 cycles. The block does not synchronise it; it is an on-chip combinational net.
- Results (truth_tbl, gate_id, is_universal, stable) hold until the next accepted start clears them.
- gate_id codes, keyed by truth_tbl:

| gate_id | Name | truth_tbl |
|---|---|---|
| 1 | AND | 1000 |
| 2 | OR | 1110 |
| 3 | NAND | 0111 |
| 4 | NOR | 0001 |
| 5 | XOR | 0110 |
| 6 | XNOR | 1001 |
| 7 | NOT_A | 0011 |
| 8 | NOT_B | 0101 |
| 9 | CONST0 | 0000 |
| 10 | CONST1 | 1111 |
| 0 | UNKNOWN | all other tables |

- Codes 11..15 are reserved and never produced.

Optional Feature:
- Macro: GATE_ID_REPEAT_CHECK_EN.
- Defined:
  - After idx 3, perform a second full sweep into a shadow table.
  - stable=1 only if the shadow table equals truth_tbl.
  - When stable=0, gate_id is forced to UNKNOWN. truth_tbl keeps the first sweep.
  - Latency doubles: done in cycle 8*(SETTLE_CYCLES+1)+1.
- Undefined: a single sweep is performed, and stable is driven to 1 in DONE and held.

Decomposition:
- Package gate_id_pkg holds:
  - the gate_id localparams (GID_UNKNOWN..GID_CONST1);
  - the truth-table constants TT_AND..TT_CONST1;
  - the FSM state encodings IDLE/RUN/DONE.
- Sub-module gate_classifier: purely combinational, truth_tbl[3:0] -> gate_id[3:0] and is_universal. Its outputs are registered in the parent on DONE.

Test Plan:
- DUT drives a NOR gate, SETTLE_CYCLES=2, start pulsed once -> done at cycle 13; truth_tbl=0001, gate_id=4, is_universal=1, busy low in the same cycle.
- Sweep over XOR, then NAND, then NOT_A (y=~a) in back-to-back runs -> gate_id 5 / 3 / 7, with truth_tbl 0110 / 0111 / 0011.
- gate_y=a&~b -> truth_tbl=0100, gate_id=0, is_universal=0; SETTLE_CYCLES=0 variant gives done at cycle 5.
- start pulsed again at cycle 6 of a running sweep -> ignored, done still only at cycle 13; then rst asserted at cycle 8 of a new sweep -> all outputs 0 asynchronously, no done pulse.
- start held high for 40 cycles with an AND gate -> done pulses every 14 cycles; truth_tbl=1000 and gate_id=1 each time.
- With GATE_ID_REPEAT_CHECK_EN, gate_y toggles between OR and AND at cycle 14 -> stable=0, gate_id=0, truth_tbl=1110, done at cycle 25.

Source files
------------

// File: rtl/gate_id_pkg.sv
// Shared codes for the gate identifier: gate_id values, reference truth tables,
// FSM states and a truth-table bit-insert helper.
package gate_id_pkg;

  localparam logic [3:0] GID_UNKNOWN = 4'd0;
  localparam logic [3:0] GID_AND     = 4'd1;
  localparam logic [3:0] GID_OR      = 4'd2;
  localparam logic [3:0] GID_NAND    = 4'd3;
  localparam logic [3:0] GID_NOR     = 4'd4;
  localparam logic [3:0] GID_XOR     = 4'd5;
  localparam logic [3:0] GID_XNOR    = 4'd6;
  localparam logic [3:0] GID_NOT_A   = 4'd7;
  localparam logic [3:0] GID_NOT_B   = 4'd8;
  localparam logic [3:0] GID_CONST0  = 4'd9;
  localparam logic [3:0] GID_CONST1  = 4'd10;

  // Bit i holds the gate output for {a,b} == i, with a as the MSB.
  localparam logic [3:0] TT_AND    = 4'b1000;
  localparam logic [3:0] TT_OR     = 4'b1110;
  localparam logic [3:0] TT_NAND   = 4'b0111;
  localparam logic [3:0] TT_NOR    = 4'b0001;
  localparam logic [3:0] TT_XOR    = 4'b0110;
  localparam logic [3:0] TT_XNOR   = 4'b1001;
  localparam logic [3:0] TT_NOT_A  = 4'b0011;
  localparam logic [3:0] TT_NOT_B  = 4'b0101;
  localparam logic [3:0] TT_CONST0 = 4'b0000;
  localparam logic [3:0] TT_CONST1 = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [3:0] tt_insert(input logic [3:0] tbl,
                                           input logic [1:0] idx,
                                           input logic       bit_v);
    logic [3:0] r;
    r      = tbl;
    r[idx] = bit_v;
    return r;
  endfunction

endpackage

// File: rtl/gate_identifier_if.sv
// Host-side handshake and result bundle of the gate identifier.
interface gate_identifier_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [3:0] truth_tbl;
  logic [3:0] gate_id;
  logic       is_universal;
  logic       stable;

  modport master (
    output start,
    input  busy, done, truth_tbl, gate_id, is_universal, stable
  );

  modport slave (
    input  start,
    output busy, done, truth_tbl, gate_id, is_universal, stable
  );
endinterface

// File: rtl/gate_classifier.sv
// Combinational map from an observed 4-bit truth table to a gate_id code
// and the NAND/NOR universality flag.
module gate_classifier
  import gate_id_pkg::*;
(
  input  logic [3:0] truth_tbl,
  output logic [3:0] gate_id,
  output logic       is_universal
);

  always_comb begin
    gate_id = GID_UNKNOWN;
    case (truth_tbl)
      TT_AND:    gate_id = GID_AND;
      TT_OR:     gate_id = GID_OR;
      TT_NAND:   gate_id = GID_NAND;
      TT_NOR:    gate_id = GID_NOR;
      TT_XOR:    gate_id = GID_XOR;
      TT_XNOR:   gate_id = GID_XNOR;
      TT_NOT_A:  gate_id = GID_NOT_A;
      TT_NOT_B:  gate_id = GID_NOT_B;
      TT_CONST0: gate_id = GID_CONST0;
      TT_CONST1: gate_id = GID_CONST1;
      default:   gate_id = GID_UNKNOWN;
    endcase
    is_universal = (gate_id == GID_NAND) || (gate_id == GID_NOR);
  end

endmodule

// File: rtl/gate_identifier.sv
// Sweeps the four input vectors of an external 2-input gate and classifies it.
// Define GATE_ID_REPEAT_CHECK_EN to add a second confirming sweep (stable flag).
module gate_identifier
  import gate_id_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
)
(
  input  logic                clk,
  input  logic                rst,
  gate_identifier_if.slave    host,
  input  logic                gate_y,
  output logic                gate_a,
  output logic                gate_b
);

  localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

  state_t     state, state_nxt;
  logic [1:0] idx;
  logic [3:0] cnt;
  logic [3:0] truth_tbl_q;
  logic [3:0] gate_id_q;
  logic       is_univ_q;
  logic       stable_q;
  logic       busy_c, done_c;

  logic       sample, last_vec, sweep_end;
  logic [3:0] cls_tbl, cls_id;
  logic       cls_univ, stable_fin;

  assign sample   = (state == RUN) && (cnt == SETTLE);
  assign last_vec = sample && (idx == 2'd3);

`ifdef GATE_ID_REPEAT_CHECK_EN
  logic       second;
  logic [3:0] shadow;

  // First sweep is already complete in truth_tbl_q; the shadow is finished this edge.
  assign sweep_end  = last_vec && second;
  assign cls_tbl    = truth_tbl_q;
  assign stable_fin = (tt_insert(shadow, idx, gate_y) == truth_tbl_q);
`else
  assign sweep_end  = last_vec;
  assign cls_tbl    = tt_insert(truth_tbl_q, idx, gate_y);
  assign stable_fin = 1'b1;
`endif

  gate_classifier u_classifier (
    .truth_tbl    (cls_tbl),
    .gate_id      (cls_id),
    .is_universal (cls_univ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: if (host.start) state_nxt = RUN;
      RUN: begin
        busy_c = 1'b1;
        if (sweep_end) state_nxt = DONE;
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // idx wraps to 0 after vector 3, so it doubles as the gate drive and is 0 outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= 2'd0;
      cnt         <= 4'd0;
      truth_tbl_q <= 4'd0;
      gate_id_q   <= GID_UNKNOWN;
      is_univ_q   <= 1'b0;
      stable_q    <= 1'b0;
`ifdef GATE_ID_REPEAT_CHECK_EN
      second      <= 1'b0;
      shadow      <= 4'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (host.start) begin
            idx         <= 2'd0;
            cnt         <= 4'd0;
            truth_tbl_q <= 4'd0;
            gate_id_q   <= GID_UNKNOWN;
            is_univ_q   <= 1'b0;
            stable_q    <= 1'b0;
`ifdef GATE_ID_REPEAT_CHECK_EN
            second      <= 1'b0;
            shadow      <= 4'd0;
`endif
          end
        end
        RUN: begin
          if (sample) begin
            cnt <= 4'd0;
            idx <= idx + 2'd1;
`ifdef GATE_ID_REPEAT_CHECK_EN
            if (second) shadow      <= tt_insert(shadow, idx, gate_y);
            else        truth_tbl_q <= tt_insert(truth_tbl_q, idx, gate_y);
            if (last_vec) second <= 1'b1;
`else
            truth_tbl_q <= tt_insert(truth_tbl_q, idx, gate_y);
`endif
            if (sweep_end) begin
              gate_id_q <= stable_fin ? cls_id : GID_UNKNOWN;
              is_univ_q <= stable_fin & cls_univ;
              stable_q  <= stable_fin;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign gate_a            = idx[1];
  assign gate_b            = idx[0];
  assign host.busy         = busy_c;
  assign host.done         = done_c;
  assign host.truth_tbl    = truth_tbl_q;
  assign host.gate_id      = gate_id_q;
  assign host.is_universal = is_univ_q;
  assign host.stable       = stable_q;

endmodule
